terminal_renderer: RTL

- Read side of the terminal text grid: scans the character buffer in step with video timing and turns each stored ASCII byte into pixels.
- Fetches glyph rows from an external font ROM and emits one 24-bit pixel per clock.
- Delays sync/active so they stay aligned with the pixel, and overlays a blinking cursor cell.
- Sits between the video timing generator, the text-grid BRAM read port and the HDMI/TMDS output.

---
 rtl/terminal_renderer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/terminal_renderer.sv
// Read side of the terminal text grid: fetches characters and glyph rows in step
// with video timing, emits one RGB pixel per clock with aligned syncs and a blinking cursor.
module terminal_renderer #(
   parameter int          SCREEN_WIDTH  = 76,
   parameter int          SCREEN_HEIGHT = 44,
   parameter int          TG_LATENCY    = 2,
   parameter int          FONT_LATENCY  = 2,
   parameter logic [23:0] FG_COLOR      = 24'h00FF00,
   parameter logic [23:0] BG_COLOR      = 24'h000000,
   parameter int          BLINK_FRAMES  = 30
) (
   input  logic                                          pixel_clk_in,
   input  logic                                          rst_in,
   input  logic [10:0]                                   hcount_in,
   input  logic [9:0]                                    vcount_in,
   input  logic                                          hsync_in,
   input  logic                                          vsync_in,
   input  logic                                          active_in,
   input  logic [$clog2(SCREEN_WIDTH)-1:0]               cursor_x_in,
   input  logic [$clog2(SCREEN_HEIGHT)-1:0]              cursor_y_in,
   input  logic                                          cursor_en_in,
   output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr,
   input  logic [7:0]                                    tg_data,
   output logic [10:0]                                   font_addr,
   input  logic [7:0]                                    font_data,
   output logic [23:0]                                   pixel_out,
   output logic                                          hsync_out,
   output logic                                          vsync_out,
   output logic                                          active_out
);

   localparam int ADDR_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
   localparam int FC_W   = $clog2(BLINK_FRAMES);
   // Stage 0 is written on the sampling edge; the last stage feeds the output registers.
   localparam int DEPTH  = TG_LATENCY + FONT_LATENCY + 2;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       active;
      logic       in_text;
      logic       cursor_hit;
      logic [2:0] glyph_row;
      logic [2:0] glyph_col;
   } stage_t;

   logic [6:0]        col;
   logic [5:0]        row;
   logic              in_text;
   logic              cursor_hit;
   logic [ADDR_W-1:0] cell_addr;
   stage_t            stage_in;
   stage_t            pipe [DEPTH];
   stage_t            last;
   logic              glyph_bit;
   logic              lit;
   logic [FC_W-1:0]   frame_cnt;
   logic              blink_on;
   logic              vsync_prev;
   logic              unused_bits;

   assign col         = hcount_in[10:4];
   assign row         = vcount_in[9:4];
   assign unused_bits = ^{hcount_in[0], vcount_in[0]};
   assign in_text     = active_in && (col < 7'(SCREEN_WIDTH)) && (row < 6'(SCREEN_HEIGHT));
   assign cursor_hit  = cursor_en_in && in_text &&
                        (8'(col) == 8'(cursor_x_in)) && (8'(row) == 8'(cursor_y_in));
   assign cell_addr   = ADDR_W'(row) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(col);

   always_comb begin
      stage_in            = '0;
      stage_in.hsync      = hsync_in;
      stage_in.vsync      = vsync_in;
      stage_in.active     = active_in;
      stage_in.in_text    = in_text;
      stage_in.cursor_hit = cursor_hit;
      stage_in.glyph_row  = vcount_in[3:1];
      stage_in.glyph_col  = hcount_in[3:1];
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
         tg_addr <= '0;
      end else begin
         pipe[0] <= stage_in;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
         tg_addr <= in_text ? cell_addr : '0;
      end
   end

   // The character byte arrives TG_LATENCY edges after tg_addr, when its sample sits in pipe[TG_LATENCY].
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) font_addr <= '0;
      else        font_addr <= {tg_data, pipe[TG_LATENCY].glyph_row};
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_cnt  <= '0;
         blink_on   <= 1'b1;
         vsync_prev <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         if (vsync_in && !vsync_prev) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink_on  <= !blink_on;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   assign last      = pipe[DEPTH-1];
   assign glyph_bit = font_data[3'd7 - last.glyph_col];
   assign lit       = glyph_bit ^ (last.cursor_hit && blink_on);

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         pixel_out  <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         active_out <= 1'b0;
      end else begin
         pixel_out  <= (last.in_text && lit) ? FG_COLOR : BG_COLOR;
         hsync_out  <= last.hsync;
         vsync_out  <= last.vsync;
         active_out <= last.active;
      end
   end

endmodule
